// File: rtl/jtframe_depth_pkg.sv
// Shared constants and helpers for the colour-depth converter.
package jtframe_depth_pkg;

    localparam int DW_MAX = 12;
    localparam int REPW   = $clog2(DW_MAX + 1);

    // 2x2 ordered-dither thresholds, indexed by {y[0], x[0]}
    localparam logic [3:0][1:0] BAYER = {2'd1, 2'd3, 2'd2, 2'd0};

    typedef struct packed {
        logic [REPW-1:0] cnt;
        logic [REPW-1:0] rem;
    } rep_t;

    // Whole copies of the input and leftover MSBs when widening
    function automatic rep_t rep_calc(input int in_dw, input int out_dw);
        rep_t r;
        r.cnt = REPW'(out_dw / in_dw);
        r.rem = REPW'(out_dw % in_dw);
        return r;
    endfunction

endpackage

// File: rtl/jtframe_depth_chan.sv
// Combinational single-channel depth scaler: MSB-cyclic widen, truncate/round/dither narrow.
// Dither path is built only when JTFRAME_DEPTH_DITHER_EN is defined.
module jtframe_depth_chan
    import jtframe_depth_pkg::*;
#(
    parameter int IN_DW  = 4,
    parameter int OUT_DW = 8,
    parameter int ROUND  = 0
)(
    input  logic [IN_DW-1:0]  d,
    input  logic [1:0]        thr,
    output logic [OUT_DW-1:0] q
);

`ifdef JTFRAME_DEPTH_DITHER_EN
    localparam bit DITHER = 1'b1;
`else
    localparam bit DITHER = 1'b0;
`endif

    logic unused_in;
    assign unused_in = ^{thr, d};

    generate
        if (OUT_DW > IN_DW) begin : g_widen
            localparam rep_t REP  = rep_calc(IN_DW, OUT_DW);
            localparam int   NREP = int'(REP.cnt);
            localparam int   NREM = int'(REP.rem);
            for (genvar k = 0; k < NREP; k++) begin : g_rep
                assign q[OUT_DW-1-k*IN_DW -: IN_DW] = d;
            end
            if (NREM != 0) begin : g_rem
                assign q[NREM-1:0] = d[IN_DW-1 -: NREM];
            end
        end else if (OUT_DW == IN_DW) begin : g_equal
            assign q = d;
        end else begin : g_narrow
            localparam int SH = IN_DW - OUT_DW;
            logic [IN_DW:0]  add, sum;
            logic [OUT_DW:0] shr;
            logic            unused_lo;
            if (DITHER && SH >= 2) begin : g_dith
                assign add = (IN_DW+1)'(thr) << (SH - 2);
            end else if (ROUND != 0) begin : g_round
                assign add = (IN_DW+1)'(1) << (SH - 1);
            end else begin : g_trunc
                assign add = '0;
            end
            // One spare MSB catches the carry so it can saturate
            assign sum       = {1'b0, d} + add;
            assign shr       = sum[IN_DW -: OUT_DW+1];
            assign unused_lo = ^sum[SH-1:0];
            assign q         = shr[OUT_DW] ? '1 : shr[OUT_DW-1:0];
        end
    endgenerate

endmodule

// File: rtl/jtframe_rgb_depth_pipe.sv
// Two-stage valid/ready colour-depth converter for packed multi-channel pixels.
// JTFRAME_DEPTH_DITHER_EN adds 2x2 ordered dither position counters.
module jtframe_rgb_depth_pipe
    import jtframe_depth_pkg::*;
#(
    parameter int CH     = 3,
    parameter int IN_DW  = 4,
    parameter int OUT_DW = 8,
    parameter int ROUND  = 0
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH*IN_DW-1:0]  in_data,
    input  logic                 in_eol,
    input  logic                 in_eof,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH*OUT_DW-1:0] out_data,
    output logic                 out_eol,
    output logic                 out_eof
);

    logic [2:1]           vld_pipe;
    logic [CH*IN_DW-1:0]  s1_data;
    logic                 s1_eol, s1_eof;
    logic [1:0]           s1_thr, thr_in;
    logic [CH*OUT_DW-1:0] scaled;
    logic                 s2_free, s1_adv, in_fire;

    assign s2_free   = ~vld_pipe[2] | out_ready;
    assign s1_adv    = vld_pipe[1] & s2_free;
    assign in_ready  = ~vld_pipe[1] | s1_adv;
    assign in_fire   = in_valid & in_ready;
    assign out_valid = vld_pipe[2];

`ifdef JTFRAME_DEPTH_DITHER_EN
    logic dx, dy;

    always_ff @(posedge clk) begin
        if (rst) begin
            dx <= 1'b0;
            dy <= 1'b0;
        end else if (in_fire) begin
            dx <= in_eol ? 1'b0 : ~dx;
            dy <= in_eof ? 1'b0 : dy ^ in_eol;
        end
    end

    assign thr_in = BAYER[{dy, dx}];
`else
    assign thr_in = 2'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            s1_data  <= '0;
            s1_eol   <= 1'b0;
            s1_eof   <= 1'b0;
            s1_thr   <= 2'd0;
            out_data <= '0;
            out_eol  <= 1'b0;
            out_eof  <= 1'b0;
        end else begin
            if (in_ready) vld_pipe[1] <= in_valid;
            if (in_fire) begin
                s1_data <= in_data;
                s1_eol  <= in_eol;
                s1_eof  <= in_eof;
                s1_thr  <= thr_in;
            end
            if (s2_free) vld_pipe[2] <= vld_pipe[1];
            if (s1_adv) begin
                out_data <= scaled;
                out_eol  <= s1_eol;
                out_eof  <= s1_eof;
            end
        end
    end

    generate
        for (genvar c = 0; c < CH; c++) begin : g_ch
            jtframe_depth_chan #(
                .IN_DW  (IN_DW),
                .OUT_DW (OUT_DW),
                .ROUND  (ROUND)
            ) u_chan (
                .d   (s1_data[c*IN_DW +: IN_DW]),
                .thr (s1_thr),
                .q   (scaled[c*OUT_DW +: OUT_DW])
            );
        end
    endgenerate

endmodule

// File: tb/tb_jtframe_rgb_depth_pipe.sv
// Scoreboard bench: six converter configurations share one handshake and one input stream.
module tb_jtframe_rgb_depth_pipe;

`ifdef JTFRAME_DEPTH_DITHER_EN
    localparam bit DITHER = 1'b1;
`else
    localparam bit DITHER = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic in_valid = 1'b0, in_eol = 1'b0, in_eof = 1'b0, out_ready = 1'b0;
    logic [11:0] w0 = '0, w1 = '0, w2 = '0;
    logic [5:0]  rdy, ovld, oeol, oeof;
    logic [23:0] od_a;
    logic [14:0] od_b, od_c;
    logic [7:0]  od_d;
    logic [3:0]  od_e;
    logic [5:0]  od_f;
    logic [11:0] in_a;
    logic [23:0] in_b;
    logic [2:0]  in_d;
    logic [7:0]  in_e;
    logic [5:0]  in_f;

    assign in_a = {w2[3:0], w1[3:0], w0[3:0]};
    assign in_b = {w2[7:0], w1[7:0], w0[7:0]};
    assign in_d = w0[2:0];
    assign in_e = w0[7:0];
    assign in_f = w0[5:0];

    jtframe_rgb_depth_pipe #(.CH(3), .IN_DW(4), .OUT_DW(8), .ROUND(0)) dut_a (.clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_a), .in_eol(in_eol), .in_eof(in_eof),
        .out_valid(ovld[0]), .out_ready(out_ready), .out_data(od_a), .out_eol(oeol[0]), .out_eof(oeof[0]));
    jtframe_rgb_depth_pipe #(.CH(3), .IN_DW(8), .OUT_DW(5), .ROUND(1)) dut_b (.clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_b), .in_eol(in_eol), .in_eof(in_eof),
        .out_valid(ovld[1]), .out_ready(out_ready), .out_data(od_b), .out_eol(oeol[1]), .out_eof(oeof[1]));
    jtframe_rgb_depth_pipe #(.CH(3), .IN_DW(8), .OUT_DW(5), .ROUND(0)) dut_c (.clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy[2]), .in_data(in_b), .in_eol(in_eol), .in_eof(in_eof),
        .out_valid(ovld[2]), .out_ready(out_ready), .out_data(od_c), .out_eol(oeol[2]), .out_eof(oeof[2]));
    jtframe_rgb_depth_pipe #(.CH(1), .IN_DW(3), .OUT_DW(8), .ROUND(0)) dut_d (.clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy[3]), .in_data(in_d), .in_eol(in_eol), .in_eof(in_eof),
        .out_valid(ovld[3]), .out_ready(out_ready), .out_data(od_d), .out_eol(oeol[3]), .out_eof(oeof[3]));
    jtframe_rgb_depth_pipe #(.CH(1), .IN_DW(8), .OUT_DW(4), .ROUND(1)) dut_e (.clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy[4]), .in_data(in_e), .in_eol(in_eol), .in_eof(in_eof),
        .out_valid(ovld[4]), .out_ready(out_ready), .out_data(od_e), .out_eol(oeol[4]), .out_eof(oeof[4]));
    jtframe_rgb_depth_pipe #(.CH(1), .IN_DW(6), .OUT_DW(6), .ROUND(0)) dut_f (.clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy[5]), .in_data(in_f), .in_eol(in_eol), .in_eof(in_eof),
        .out_valid(ovld[5]), .out_ready(out_ready), .out_data(od_f), .out_eol(oeol[5]), .out_eof(oeof[5]));

    typedef struct {
        logic [23:0] a;
        logic [14:0] b, c;
        logic [7:0]  d;
        logic [3:0]  e;
        logic [5:0]  f;
        logic        eol, eof;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int checks = 0, errors = 0;
    int n_acc = 0, n_emit = 0, col = 0, row = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference scaling straight from the arithmetic definitions
    function automatic int unsigned scale(int unsigned d, int iw, int ow, int rnd, int thr);
        int unsigned q, mx;
        int sh;
        mx = (1 << ow) - 1;
        if (ow > iw) begin
            q = 0;
            for (int i = 0; i < ow; i++)
                q |= ((d >> (iw - 1 - (i % iw))) & 1) << (ow - 1 - i);
        end else if (ow == iw) begin
            q = d;
        end else begin
            sh = iw - ow;
            if (DITHER && sh >= 2) q = (d + thr * (1 << (sh - 2))) >> sh;
            else if (rnd != 0)     q = (d + (1 << (sh - 1))) >> sh;
            else                   q = d >> sh;
            if (q > mx) q = mx;
        end
        return q;
    endfunction

    function automatic int bayer(int r, int c);
        int tab[4] = '{0, 2, 3, 1};
        return tab[(r % 2) * 2 + (c % 2)];
    endfunction

    function automatic exp_t model(logic [11:0] c0, logic [11:0] c1, logic [11:0] c2,
                                   logic eol, logic eof, int thr);
        exp_t e;
        int unsigned c[3];
        c[0] = c0; c[1] = c1; c[2] = c2;
        e.a = '0; e.b = '0; e.c = '0;
        for (int ch = 0; ch < 3; ch++) begin
            e.a |= 24'(scale(c[ch] & 'hF, 4, 8, 0, thr)) << (8 * ch);
            e.b |= 15'(scale(c[ch] & 'hFF, 8, 5, 1, thr)) << (5 * ch);
            e.c |= 15'(scale(c[ch] & 'hFF, 8, 5, 0, thr)) << (5 * ch);
        end
        e.d = 8'(scale(c[0] & 'h7, 3, 8, 0, thr));
        e.e = 4'(scale(c[0] & 'hFF, 8, 4, 1, thr));
        e.f = 6'(scale(c[0] & 'h3F, 6, 6, 0, thr));
        e.eol = eol;
        e.eof = eof;
        return e;
    endfunction

    // Stimulus recorder: every accepted word pushes its expected result
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            n_acc = 0; col = 0; row = 0;
        end else if (in_valid && rdy[0]) begin
            sb.push_back(model(w0, w1, w2, in_eol, in_eof, bayer(row, col)));
            n_acc++;
            if (in_eol) col = 0; else col++;
            if (in_eof) row = 0; else if (in_eol) row++;
        end
    end

    // Monitor: every emitted word pops and compares
    always @(negedge clk) begin
        if (rst) begin
            n_emit = 0;
        end else if (ovld[0] && out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("data_a", 32'(od_a), 32'(mon_e.a));
                chk("data_b", 32'(od_b), 32'(mon_e.b));
                chk("data_c", 32'(od_c), 32'(mon_e.c));
                chk("data_d", 32'(od_d), 32'(mon_e.d));
                chk("data_e", 32'(od_e), 32'(mon_e.e));
                chk("data_f", 32'(od_f), 32'(mon_e.f));
                chk("eol", 32'(oeol), mon_e.eol ? 32'h3f : 32'h0);
                chk("eof", 32'(oeof), mon_e.eof ? 32'h3f : 32'h0);
            end
            chk("valid_agree", 32'(ovld), 32'h3f);
            n_emit++;
        end
    end

    // Back-pressure only when two words are held and downstream refuses
    always @(posedge clk) begin
        #2;
        if (!rst)
            chk("in_ready", 32'(rdy), ((n_acc - n_emit) == 2 && !out_ready) ? 32'h0 : 32'h3f);
    end

    task automatic drive(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c,
                         input logic eol, input logic eof);
        w0 = a; w1 = b; w2 = c; in_eol = eol; in_eof = eof;
    endtask

    task automatic send_dir(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c,
                            input logic eol, input logic eof);
        out_ready = 1'b1;
        drive(a, b, c, eol, eof);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("lat1_valid", 32'(ovld), 32'h0);
        @(posedge clk); #1;
        chk("lat2_valid", 32'(ovld), 32'h3f);
    endtask

    task automatic stream_word(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c,
                               input logic eol, input logic eof);
        bit acc = 1'b0;
        drive(a, b, c, eol, eof);
        in_valid = 1'b1;
        for (int k = 0; k < 64 && !acc; k++) begin
            @(negedge clk);
            acc = rdy[0];
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        while ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] ex10[4], ex18[4], tab3[8];
        logic eol, eof;
        tab3 = '{8'h00, 8'h24, 8'h49, 8'h6D, 8'h92, 8'hB6, 8'hDB, 8'hFF};
        ex10 = '{8'h1, 8'h1, 8'h1, 8'h1};
`ifdef JTFRAME_DEPTH_DITHER_EN
        ex18 = '{8'h1, 8'h2, 8'h2, 8'h1};
`else
        ex18 = '{8'h2, 8'h2, 8'h2, 8'h2};
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(ovld), 32'h0);
        chk("rst_data_a", 32'(od_a), 32'h0);
        chk("rst_flags", 32'({oeol, oeof}), 32'h0);
        chk("rst_ready", 32'(rdy), 32'h3f);
        rst = 1'b0;

        // 2x2 block, eol every 2 pixels, eof closing the block
        for (int k = 0; k < 4; k++) begin
            send_dir(12'h010, 12'h0, 12'h0, k[0], k == 3);
            chk("blk10_e", 32'(od_e), 32'(ex10[k]));
        end
        for (int k = 0; k < 4; k++) begin
            send_dir(12'h018, 12'h0, 12'h0, k[0], k == 3);
            chk("blk18_e", 32'(od_e), 32'(ex18[k]));
        end

        send_dir(12'h00C, 12'h00B, 12'h00A, 1'b1, 1'b1);
        chk("widen_abc", 32'(od_a), 32'hAABBCC);
        chk("widen3_4", 32'(od_d), 32'h92);
        send_dir(12'h0FF, 12'h004, 12'h003, 1'b1, 1'b1);
        chk("narrow_rnd", 32'(od_b), DITHER ? 32'h1F : 32'h3F);
        chk("narrow_trunc", 32'(od_c), 32'h1F);
        send_dir(12'h007, 12'h080, 12'h07F, 1'b1, 1'b1);
        chk("narrow_trunc2", 32'(od_c), 32'h3E00);
        for (int i = 0; i < 8; i++) begin
            send_dir(12'(i), 12'h0, 12'h0, 1'b1, 1'b1);
            chk("widen3_tab", 32'(od_d), 32'(tab3[i]));
        end

        // Reset with a full pipe, then a fresh word must see normal latency
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(12'h1, 12'h2, 12'h3, 1'b0, 1'b0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        drive(12'h4, 12'h5, 12'h6, 1'b1, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_valid", 32'(ovld), 32'h0);
        chk("midrst_ready", 32'(rdy), 32'h3f);
        send_dir(12'h7, 12'h7, 12'h7, 1'b1, 1'b1);
        chk("postrst_a", 32'(od_a), 32'h777777);

        for (int n = 0; n < 300; n++) begin
            if (n < 16) begin
                stream_word(12'(n), 12'(n + 1), 12'(n + 2), n % 4 == 3, n == 15);
            end else begin
                eol = ($urandom_range(0, 3) == 0);
                eof = ($urandom_range(0, 5) == 0);
                stream_word(12'($urandom), 12'($urandom), 12'($urandom), eol, eof);
            end
        end

        out_ready = 1'b1;
        for (int k = 0; k < 20 && sb.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        chk("drain_empty", 32'(sb.size()), 32'h0);
        @(posedge clk); #1;
        chk("idle_valid", 32'(ovld), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
